// File: rtl/and16_share_arb.sv
// rtl/and16_share_arb.sv - round-robin arbiter sharing one CHUNK-sliced 16-input AND reducer
// Optional early exit on a zero slice: define AND16_EARLY_EXIT_EN.
module and16_share_arb #(
    parameter int NREQ  = 4,
    parameter int CHUNK = 4,
    parameter int ID_W  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VALID,
    input  logic [16*NREQ-1:0]   REQ_DATA,
    output logic [NREQ-1:0]      REQ_READY,
    output logic                 RES_VALID,
    output logic                 RES_O,
    output logic [ID_W-1:0]      RES_ID,
    input  logic                 RES_READY,
    output logic                 BUSY
);
    localparam int NCHUNK = 16 / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [15:0]       op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [15:0]       win_data;
    logic              xfer;
    logic              slice_ones;

    // Search starts one past the last winner so every waiting requester gets a turn.
    always_comb begin
        grant  = '0;
        win_id = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NREQ);
            if (!found && REQ_VALID[cand]) begin
                grant[cand] = 1'b1;
                win_id      = cand;
                found       = 1'b1;
            end
        end
    end

    assign REQ_READY  = (state_q == IDLE && !RST) ? grant : '0;
    assign xfer       = |(REQ_VALID & REQ_READY);
    assign win_data   = REQ_DATA[16*win_id +: 16];
    assign slice_ones = &op_q[CHUNK*cnt_q +: CHUNK];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        id_d    = id_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    op_d    = win_data;
                    id_d    = win_id;
                    ptr_d   = win_id;
                    acc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_d = acc_q & slice_ones;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
`ifdef AND16_EARLY_EXIT_EN
                if (!slice_ones) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (RES_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NREQ - 1);
            op_q    <= '0;
            id_q    <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RES_VALID = (state_q == DONE);
    assign RES_O     = RES_VALID & acc_q;
    assign RES_ID    = RES_VALID ? id_q : '0;
    assign BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_and16_share_arb.sv
// tb/tb_and16_share_arb.sv - table-driven self-checking bench for and16_share_arb
module tb_and16_share_arb;
    logic        CLK;
    logic        RST;
    logic [3:0]  REQ_VALID;
    logic [63:0] REQ_DATA;
    logic [3:0]  REQ_READY;
    logic        RES_VALID;
    logic        RES_O;
    logic [1:0]  RES_ID;
    logic        RES_READY;
    logic        BUSY;

    and16_share_arb #(.NREQ(4), .CHUNK(4), .ID_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .RES_VALID(RES_VALID), .RES_O(RES_O), .RES_ID(RES_ID),
        .RES_READY(RES_READY), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        int          id;
        logic        res;
        int          lat_full;
        int          lat_early;
        int          stall;
    } vec_t;

    vec_t tbl[12];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t t);
`ifdef AND16_EARLY_EXIT_EN
        return t.lat_early;
`else
        return t.lat_full;
`endif
    endfunction

    task automatic run_op(input vec_t t, input int n);
        int lat;
        @(negedge CLK);
        RES_READY = (t.stall == 0);
        REQ_VALID = t.v;
        REQ_DATA  = t.d;
        #1;
        check($sformatf("grant[%0d]", n), {60'd0, REQ_READY}, 64'(4'b0001 << t.id));
        @(posedge CLK);
        #1;
        check($sformatf("busy_eval[%0d]", n), {63'd0, BUSY}, 64'd1);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!RES_VALID && lat < 20);
        check($sformatf("latency[%0d]", n), 64'(lat), 64'(exp_lat(t)));
        check($sformatf("res_o[%0d]", n), {63'd0, RES_O}, {63'd0, t.res});
        check($sformatf("res_id[%0d]", n), {62'd0, RES_ID}, 64'(t.id));
        check($sformatf("busy_done[%0d]", n), {63'd0, BUSY}, 64'd1);
        for (int s = 0; s < t.stall; s++) begin
            @(posedge CLK);
            #1;
            check($sformatf("stall_valid[%0d]", s), {63'd0, RES_VALID}, 64'd1);
            check($sformatf("stall_res_o[%0d]", s), {63'd0, RES_O}, {63'd0, t.res});
            check($sformatf("stall_res_id[%0d]", s), {62'd0, RES_ID}, 64'(t.id));
            check($sformatf("stall_ready[%0d]", s), {60'd0, REQ_READY}, 64'd0);
        end
        if (t.stall != 0) begin
            @(negedge CLK);
            RES_READY = 1'b1;
            REQ_VALID = 4'b0000;
        end
        @(posedge CLK);
        #1;
        check($sformatf("res_drop[%0d]", n), {63'd0, RES_VALID}, 64'd0);
    endtask

    initial begin
        int   seen;
        vec_t post;

        tbl[0]  = '{4'b0001, 64'h0000_0000_0000_FFFF, 0, 1'b1, 4, 4, 0};
        tbl[1]  = '{4'b1111, 64'hFFFF_FFEF_FFFF_FFFF, 1, 1'b1, 4, 4, 0};
        tbl[2]  = '{4'b1111, 64'hFFFF_FFEF_FFFF_FFFF, 2, 1'b0, 4, 2, 0};
        tbl[3]  = '{4'b1111, 64'hFFFF_FFEF_FFFF_FFFF, 3, 1'b1, 4, 4, 0};
        tbl[4]  = '{4'b1111, 64'hFFFF_FFEF_FFFF_FFFF, 0, 1'b1, 4, 4, 0};
        tbl[5]  = '{4'b1111, 64'hFFFF_FFEF_FFFF_FFFF, 1, 1'b1, 4, 4, 0};
        tbl[6]  = '{4'b0001, 64'h0000_0000_0000_FFF0, 0, 1'b0, 4, 1, 0};
        tbl[7]  = '{4'b1010, 64'hFFFF_0000_0FFF_0000, 1, 1'b0, 4, 4, 0};
        tbl[8]  = '{4'b1001, 64'hFFFF_0000_0000_FFFF, 3, 1'b1, 4, 4, 0};
        tbl[9]  = '{4'b1000, 64'hFFFF_0000_0000_0000, 3, 1'b1, 4, 4, 0};
        tbl[10] = '{4'b1000, 64'hFFFF_0000_0000_0000, 3, 1'b1, 4, 4, 0};
        tbl[11] = '{4'b0010, 64'h0000_0000_7FFF_0000, 1, 1'b0, 4, 4, 10};

        RST       = 1'b1;
        REQ_VALID = 4'b1111;
        REQ_DATA  = 64'hFFFF_FFFF_FFFF_FFFF;
        RES_READY = 1'b1;
        #12;
        check("rst_req_ready", {60'd0, REQ_READY}, 64'd0);
        check("rst_res_valid", {63'd0, RES_VALID}, 64'd0);
        check("rst_res_o", {63'd0, RES_O}, 64'd0);
        check("rst_res_id", {62'd0, RES_ID}, 64'd0);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        @(negedge CLK);
        REQ_VALID = 4'b0000;
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i], i);
        end

        // Async reset in the middle of EVAL discards the operand.
        @(negedge CLK);
        REQ_VALID = 4'b0100;
        REQ_DATA  = 64'h0000_FFFF_0000_0000;
        RES_READY = 1'b1;
        #1;
        check("mid_rst_grant", {60'd0, REQ_READY}, 64'b0100);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, RES_VALID}, 64'd0);
        check("mid_rst_busy", {63'd0, BUSY}, 64'd0);
        check("mid_rst_ready", {60'd0, REQ_READY}, 64'd0);
        check("mid_rst_res_o", {63'd0, RES_O}, 64'd0);
        check("mid_rst_res_id", {62'd0, RES_ID}, 64'd0);
        @(negedge CLK);
        REQ_VALID = 4'b0000;
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #1;
            if (RES_VALID) seen++;
        end
        check("post_rst_no_result", 64'(seen), 64'd0);
        post = '{4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 4, 4, 0};
        run_op(post, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/and16_share_arb.md
Name: and16_share_arb

Overview:
- Arbitrates and sequences one shared 16-input AND-reduction unit among NREQ requesters.
- Each requester presents a 16-bit operand word. The block grants requesters round-robin, evaluates the AND of all 16 bits in CHUNK-bit slices over several cycles, and returns a 1-bit result tagged with the requester ID.
- Sits between multiple control-path clients and a single time-multiplexed wide-AND resource, in place of one 16-input AND gate per client.

Parameters:
NREQ, 4, number of requesters (2..8)
CHUNK, 4, bits reduced per EVAL cycle; must divide 16 (1, 2, 4, 8, 16); NCHUNK = 16/CHUNK
ID_W, 2, width of RES_ID; 2^ID_W >= NREQ

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
REQ_VALID  input  NREQ  per-requester operand valid
REQ_DATA  input  16*NREQ  operands; requester i at bits [16*i+15:16*i]
REQ_READY  output  NREQ  one-hot grant; transfer when REQ_VALID[i] & REQ_READY[i] at a clock edge
RES_VALID  output  1  result valid
RES_O  output  1  AND of all 16 captured operand bits
RES_ID  output  ID_W  index of the requester whose operand produced RES_O
RES_READY  input  1  result consumer ready
BUSY  output  1  high in EVAL or DONE

Behaviour:
- Reset (async, RST=1): state=IDLE, priority pointer=NREQ-1 so requester 0 wins first. REQ_READY=0, RES_VALID=0, RES_O=0, RES_ID=0, BUSY=0. Captured operand, accumulator and chunk counter cleared.
- Reset mid-operation: in-flight operand discarded; no RES_VALID is produced for it after release.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - REQ_READY is combinational: a one-hot bit for the first i with REQ_VALID[i]=1, searching from pointer+1 upward with wrap-around. All zero if no REQ_VALID.
  - At most one bit of REQ_READY is set.
  - On transfer: capture the operand and ID, set pointer=winner, acc=1, cnt=0, go to EVAL.
- EVAL:
  - Each cycle: acc <= acc & (&operand[CHUNK*cnt +: CHUNK]); cnt <= cnt+1.
  - After slice NCHUNK-1 is processed: go to DONE with RES_O = final acc.
  - REQ_READY=0 throughout.
- DONE:
  - RES_VALID=1; RES_O and RES_ID stable until RES_VALID & RES_READY at an edge.
  - On that edge: go to IDLE, RES_VALID=0.
  - No new acceptance in DONE; at the earliest, the next grant is the cycle after the result handshake.
- Latency: RES_VALID rises NCHUNK edges after the request-transfer edge (4 with defaults).
- Throughput: one operation per NCHUNK+2 cycles at best.
- Fairness: a requester holding REQ_VALID continuously is granted within NREQ operations.
- Requesters may drop REQ_VALID before a grant without penalty. REQ_DATA is sampled only on the transfer edge.
- RES_READY held low stalls DONE indefinitely; RES_O and RES_ID must not change while stalled.
- CHUNK=16: EVAL lasts exactly one cycle.

Optional Feature:
- Macro: AND16_EARLY_EXIT_EN.
- Defined: in EVAL, if the slice being reduced contains any 0, go to DONE on that edge with RES_O=0, skipping the remaining slices. Latency is then 1..NCHUNK edges, depending on the first zero slice. An all-ones operand still takes NCHUNK edges.
- Undefined: fixed NCHUNK-edge EVAL regardless of data.

Test Plan:
- Reset, then REQ_VALID=4'b0001, REQ_DATA[15:0]=16'hFFFF, RES_READY=1 -> REQ_READY=4'b0001 at once; RES_VALID=1 4 edges after transfer with RES_O=1, RES_ID=0; BUSY high through DONE.
- REQ_VALID=4'b1111, all operands 16'hFFFF except req2=16'hFFEF, RES_READY=1 -> grants in order 0,1,2,3,0; results 1,1,0,1 with matching RES_ID.
- Req1 operand 16'h7FFF, RES_READY=0 for 10 cycles -> RES_VALID stays 1 with RES_O=0, RES_ID=1 stable; REQ_READY=0 throughout; RES_READY=1 -> IDLE next edge.
- Req0 operand 16'hFFF0 (slice 0 zero): with AND16_EARLY_EXIT_EN, RES_VALID 1 edge after transfer with RES_O=0; without it, 4 edges, RES_O=0.
- Assert RST asynchronously during EVAL (between edges) -> all outputs 0 immediately; after release with REQ_VALID=0, RES_VALID never asserts; next grant goes to requester 0.
- Pointer at 3, only REQ_VALID[3] asserted repeatedly -> requester 3 re-granted each operation (no gap beyond DONE->IDLE).
